// File: rtl/clock_set_ctrl.sv
// Time-setting controller for the 24-hour BCD clock: debounced MODE/INC buttons,
// RUN/SET_HR/SET_MIN/COMMIT editing of a shadow HH:MM, parallel load and blink masks.
module clock_set_ctrl #(
    parameter int DB_CYCLES = 20,
    parameter int RPT_DELAY = 100,
    parameter int RPT_RATE  = 25,
    parameter int BLINK_DIV = 50,
    parameter int IDLE_TO   = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic [3:0] cur_h_tens,
    input  logic [3:0] cur_h_ones,
    input  logic [3:0] cur_m_tens,
    input  logic [3:0] cur_m_ones,
    output logic       run_en,
    output logic       load,
    output logic [3:0] ld_h_tens,
    output logic [3:0] ld_h_ones,
    output logic [3:0] ld_m_tens,
    output logic [3:0] ld_m_ones,
    output logic [3:0] blink_mask,
    output logic [1:0] mode
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        COMMIT  = 2'b11
    } state_t;

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam int RMX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int RW  = $clog2(RMX + 1);
    localparam int BW  = $clog2(BLINK_DIV + 1);
    localparam int IW  = $clog2(IDLE_TO + 1);

    function automatic logic [7:0] inc_hour(input logic [3:0] t, input logic [3:0] o);
        if (t == 4'd2 && o == 4'd3) return 8'h00;
        else if (o == 4'd9)         return {t + 4'd1, 4'd0};
        else                        return {t, o + 4'd1};
    endfunction

    function automatic logic [7:0] inc_min(input logic [3:0] t, input logic [3:0] o);
        if (t == 4'd5 && o == 4'd9) return 8'h00;
        else if (o == 4'd9)         return {t + 4'd1, 4'd0};
        else                        return {t, o + 4'd1};
    endfunction

    // Bit 0 is MODE, bit 1 is INC.
    logic [1:0]     sync1, sync2, db, db_d;
    logic [DBW-1:0] db_cnt [2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            db_d  <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= {btn_inc, btn_mode};
            sync2 <= sync1;
            db_d  <= db;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DBW'(DB_CYCLES - 1)) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

    state_t        state, state_nxt;
    logic [3:0]    sh_ht, sh_ho, sh_mt, sh_mo;
    logic [3:0]    sh_ht_nxt, sh_ho_nxt, sh_mt_nxt, sh_mo_nxt;
    logic          rpt_arm, rpt_on, rpt_arm_nxt, rpt_on_nxt;
    logic [RW-1:0] rpt_cnt, rpt_cnt_nxt;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic          phase, phase_nxt;
    logic [IW-1:0] idle_cnt, idle_cnt_nxt;
    logic          mode_press, inc_press, in_set, nxt_set, changing;
    logic          rpt_fire, mode_evt, inc_evt, idle_expire;

    always_comb begin
        mode_press  = db[0] & ~db_d[0];
        inc_press   = db[1] & ~db_d[1];
        in_set      = (state == SET_HR) || (state == SET_MIN);
        rpt_fire    = rpt_arm && db[1] &&
                      ((!rpt_on && rpt_cnt == RW'(RPT_DELAY - 1)) ||
                       ( rpt_on && rpt_cnt == RW'(RPT_RATE - 1)));
        mode_evt    = mode_press && (state != COMMIT);
        inc_evt     = (inc_press || rpt_fire) && !mode_press && in_set;
        idle_expire = in_set && (idle_cnt == IW'(IDLE_TO - 1));

        state_nxt = state;
        sh_ht_nxt = sh_ht;
        sh_ho_nxt = sh_ho;
        sh_mt_nxt = sh_mt;
        sh_mo_nxt = sh_mo;
        case (state)
            RUN: begin
                if (mode_evt) begin
                    state_nxt = SET_HR;
                    if ((cur_h_tens < 4'd2 && cur_h_ones <= 4'd9) ||
                        (cur_h_tens == 4'd2 && cur_h_ones <= 4'd3)) begin
                        sh_ht_nxt = cur_h_tens;
                        sh_ho_nxt = cur_h_ones;
                    end else begin
                        sh_ht_nxt = 4'd0;
                        sh_ho_nxt = 4'd0;
                    end
                    if (cur_m_tens <= 4'd5 && cur_m_ones <= 4'd9) begin
                        sh_mt_nxt = cur_m_tens;
                        sh_mo_nxt = cur_m_ones;
                    end else begin
                        sh_mt_nxt = 4'd0;
                        sh_mo_nxt = 4'd0;
                    end
                end
            end
            SET_HR: begin
                if (mode_evt)         state_nxt = SET_MIN;
                else if (inc_evt)     {sh_ht_nxt, sh_ho_nxt} = inc_hour(sh_ht, sh_ho);
                else if (idle_expire) state_nxt = RUN;
            end
            SET_MIN: begin
                if (mode_evt)         state_nxt = COMMIT;
                else if (inc_evt)     {sh_mt_nxt, sh_mo_nxt} = inc_min(sh_mt, sh_mo);
                else if (idle_expire) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase

        changing = (state_nxt != state);
        nxt_set  = (state_nxt == SET_HR) || (state_nxt == SET_MIN);

        // Repeat is armed only by a press accepted in a SET state, so holding INC
        // across a state change never resumes repeating.
        rpt_arm_nxt = rpt_arm;
        rpt_on_nxt  = rpt_on;
        rpt_cnt_nxt = rpt_cnt;
        if (changing || !db[1]) begin
            rpt_arm_nxt = 1'b0;
            rpt_on_nxt  = 1'b0;
            rpt_cnt_nxt = '0;
        end else if (inc_press && inc_evt) begin
            rpt_arm_nxt = 1'b1;
            rpt_on_nxt  = 1'b0;
            rpt_cnt_nxt = '0;
        end else if (rpt_fire) begin
            rpt_on_nxt  = 1'b1;
            rpt_cnt_nxt = '0;
        end else if (rpt_arm) begin
            rpt_cnt_nxt = rpt_cnt + RW'(1);
        end

        idle_cnt_nxt = '0;
        if (nxt_set && !changing && !inc_evt) idle_cnt_nxt = idle_cnt + IW'(1);

        blink_cnt_nxt = '0;
        phase_nxt     = 1'b0;
        if (nxt_set && !changing) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                phase_nxt = ~phase;
            end else begin
                blink_cnt_nxt = blink_cnt + BW'(1);
                phase_nxt     = phase;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            sh_ht      <= '0;
            sh_ho      <= '0;
            sh_mt      <= '0;
            sh_mo      <= '0;
            rpt_arm    <= 1'b0;
            rpt_on     <= 1'b0;
            rpt_cnt    <= '0;
            blink_cnt  <= '0;
            phase      <= 1'b0;
            idle_cnt   <= '0;
            run_en     <= 1'b1;
            load       <= 1'b0;
            ld_h_tens  <= '0;
            ld_h_ones  <= '0;
            ld_m_tens  <= '0;
            ld_m_ones  <= '0;
            blink_mask <= '0;
            mode       <= 2'b00;
        end else begin
            state     <= state_nxt;
            sh_ht     <= sh_ht_nxt;
            sh_ho     <= sh_ho_nxt;
            sh_mt     <= sh_mt_nxt;
            sh_mo     <= sh_mo_nxt;
            rpt_arm   <= rpt_arm_nxt;
            rpt_on    <= rpt_on_nxt;
            rpt_cnt   <= rpt_cnt_nxt;
            blink_cnt <= blink_cnt_nxt;
            phase     <= phase_nxt;
            idle_cnt  <= idle_cnt_nxt;
            run_en    <= (state_nxt == RUN);
            load      <= (state_nxt == COMMIT);
            mode      <= state_nxt;
            if (state_nxt == COMMIT) begin
                ld_h_tens <= sh_ht_nxt;
                ld_h_ones <= sh_ho_nxt;
                ld_m_tens <= sh_mt_nxt;
                ld_m_ones <= sh_mo_nxt;
            end
            case (state_nxt)
                SET_HR:  blink_mask <= {phase_nxt, phase_nxt, 2'b00};
                SET_MIN: blink_mask <= {2'b00, phase_nxt, phase_nxt};
                default: blink_mask <= 4'b0000;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized scoreboard bench for clock_set_ctrl: expected mode sequence and load
// values are queued at stimulus time and checked by an independent monitor.
module tb_clock_set_ctrl;

    localparam int GAP = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] cur_h_tens = '0, cur_h_ones = '0, cur_m_tens = '0, cur_m_ones = '0;
    logic       run_en, load;
    logic [3:0] ld_h_tens, ld_h_ones, ld_m_tens, ld_m_ones, blink_mask;
    logic [1:0] mode;

    int         checks = 0;
    int         errors = 0;
    int         exp_mode_q[$];
    int         exp_load_q[$];
    int         hh, mm;
    bit         mon_en = 1'b0;
    logic [1:0] prev_mode = 2'b00;

    clock_set_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .cur_h_tens (cur_h_tens),
        .cur_h_ones (cur_h_ones),
        .cur_m_tens (cur_m_tens),
        .cur_m_ones (cur_m_ones),
        .run_en     (run_en),
        .load       (load),
        .ld_h_tens  (ld_h_tens),
        .ld_h_ones  (ld_h_ones),
        .ld_m_tens  (ld_m_tens),
        .ld_m_ones  (ld_m_ones),
        .blink_mask (blink_mask),
        .mode       (mode)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: times kept as plain integers, buttons as press counts.
    function automatic int nIncs(input int hold);
        if (hold < 100) return 1;
        return 2 + (hold - 100) / 25;
    endfunction

    function automatic int captureHour(input int t, input int o);
        if (t <= 9 && o <= 9 && t * 10 + o <= 23) return t * 10 + o;
        return 0;
    endfunction

    function automatic int captureMin(input int t, input int o);
        if (t <= 9 && o <= 9 && t * 10 + o <= 59) return t * 10 + o;
        return 0;
    endfunction

    function automatic int toBcd(input int h, input int m);
        return ((h / 10) << 12) | ((h % 10) << 8) | ((m / 10) << 4) | (m % 10);
    endfunction

    // which: 0 = MODE, 1 = INC, 2 = both together
    task automatic pressButton(input int which, input int hold);
        @(negedge clk);
        btn_mode = (which != 1);
        btn_inc  = (which != 0);
        repeat (hold) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic pickHold(input bit long_ok, output int hold);
        if (long_ok && $urandom_range(0, 2) == 0) hold = 112 + 25 * $urandom_range(0, 3);
        else                                      hold = $urandom_range(25, 80);
    endtask

    task automatic waitMode(input int m, input int budget, output int cycles);
        cycles = 0;
        while (mode != 2'(m) && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (mode != 2'(m)) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_mode: got %0d expected %0d within %0d cycles", mode, m, budget);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] cur, input int n_hr, input int n_min,
                                 input bit long_ok);
        int hold;
        {cur_h_tens, cur_h_ones, cur_m_tens, cur_m_ones} = cur;
        hh = captureHour(int'(cur[15:12]), int'(cur[11:8]));
        mm = captureMin(int'(cur[7:4]), int'(cur[3:0]));
        exp_mode_q.push_back(1);
        pressButton(0, 30);
        for (int i = 0; i < n_hr; i++) begin
            pickHold(long_ok, hold);
            hh = (hh + nIncs(hold)) % 24;
            pressButton(1, hold);
        end
        exp_mode_q.push_back(2);
        pressButton(0, 30);
        for (int i = 0; i < n_min; i++) begin
            pickHold(long_ok, hold);
            mm = (mm + nIncs(hold)) % 60;
            pressButton(1, hold);
        end
        exp_mode_q.push_back(3);
        exp_mode_q.push_back(0);
        exp_load_q.push_back(toBcd(hh, mm));
        pressButton(0, 30);
    endtask

    // Monitor: consumes the scoreboard whenever the DUT changes mode or loads.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mode != prev_mode) begin
                    if (exp_mode_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_mode: got %0d expected no change", mode);
                    end else begin
                        checkOutput("mode_seq", int'(mode), exp_mode_q.pop_front());
                    end
                    prev_mode = mode;
                end
                if (load) begin
                    if (exp_load_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_load: got %h%h:%h%h expected none",
                                 ld_h_tens, ld_h_ones, ld_m_tens, ld_m_ones);
                    end else begin
                        checkOutput("load_value", int'({ld_h_tens, ld_h_ones, ld_m_tens, ld_m_ones}),
                                    exp_load_q.pop_front());
                    end
                    checkOutput("run_en_at_load", int'(run_en), 0);
                end
                checkOutput("run_en_vs_mode", int'(run_en), int'(mode == 2'b00));
                case (mode)
                    2'b01:   checkOutput("blink_hr_low", int'(blink_mask[1:0]), 0);
                    2'b10:   checkOutput("blink_min_high", int'(blink_mask[3:2]), 0);
                    default: checkOutput("blink_off", int'(blink_mask), 0);
                endcase
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int found;
        repeat (3) @(negedge clk);
        checkOutput("reset_run_en", int'(run_en), 1);
        checkOutput("reset_mode", int'(mode), 0);
        checkOutput("reset_load", int'(load), 0);
        checkOutput("reset_blink", int'(blink_mask), 0);
        checkOutput("reset_ld", int'({ld_h_tens, ld_h_ones, ld_m_tens, ld_m_ones}), 0);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] directed edit 09:58 -> 11:01");
        applyStimulus(16'h0958, 2, 3, 1'b0);
        $display("[TB] wrap 23:59 -> 00:00");
        applyStimulus(16'h2359, 1, 1, 1'b0);
        $display("[TB] invalid capture 2A:61");
        applyStimulus(16'h2A61, 0, 0, 1'b0);

        $display("[TB] bounce and auto-repeat");
        {cur_h_tens, cur_h_ones, cur_m_tens, cur_m_ones} = 16'h0730;
        exp_mode_q.push_back(1);
        pressButton(0, 30);
        pressButton(1, 10);
        pressButton(1, 210);
        exp_mode_q.push_back(2);
        pressButton(0, 30);
        exp_mode_q.push_back(3);
        exp_mode_q.push_back(0);
        exp_load_q.push_back(toBcd((7 + nIncs(210)) % 24, 30));
        pressButton(0, 30);

        $display("[TB] simultaneous MODE and INC");
        {cur_h_tens, cur_h_ones, cur_m_tens, cur_m_ones} = 16'h1205;
        exp_mode_q.push_back(1);
        pressButton(0, 30);
        exp_mode_q.push_back(2);
        pressButton(2, 30);
        pressButton(1, 30);
        exp_mode_q.push_back(3);
        exp_mode_q.push_back(0);
        exp_load_q.push_back(toBcd(12, 6));
        pressButton(0, 30);

        $display("[TB] reset during SET_MIN");
        {cur_h_tens, cur_h_ones, cur_m_tens, cur_m_ones} = 16'h1437;
        exp_mode_q.push_back(1);
        pressButton(0, 30);
        exp_mode_q.push_back(2);
        pressButton(0, 30);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (blink_mask == 4'b0011) found = 1;
        end
        checkOutput("blink_min_phase", found, 1);
        exp_mode_q.push_back(0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midreset_run_en", int'(run_en), 1);
        checkOutput("midreset_mode", int'(mode), 0);
        checkOutput("midreset_load", int'(load), 0);
        checkOutput("midreset_blink", int'(blink_mask), 0);
        checkOutput("midreset_ld", int'({ld_h_tens, ld_h_ones, ld_m_tens, ld_m_ones}), 0);
        rst = 1'b1;
        repeat (100) @(negedge clk);

        $display("[TB] idle timeout with blink");
        {cur_h_tens, cur_h_ones, cur_m_tens, cur_m_ones} = 16'h0815;
        exp_mode_q.push_back(1);
        @(negedge clk);
        btn_mode = 1'b1;
        waitMode(1, 100, k);
        btn_mode = 1'b0;
        k = 0;
        while (k < 170) begin
            @(negedge clk);
            k++;
            if (k == 10)  checkOutput("blink_hr_k10", int'(blink_mask), 4'b0000);
            if (k == 60)  checkOutput("blink_hr_k60", int'(blink_mask), 4'b1100);
            if (k == 110) checkOutput("blink_hr_k110", int'(blink_mask), 4'b0000);
            if (k == 160) checkOutput("blink_hr_k160", int'(blink_mask), 4'b1100);
        end
        while (k < 1990) begin
            @(negedge clk);
            k++;
        end
        checkOutput("before_timeout_mode", int'(mode), 1);
        exp_mode_q.push_back(0);
        while (mode != 2'b00 && k < 2100) begin
            @(negedge clk);
            k++;
        end
        checkOutput("timeout_window", int'(k >= 1995 && k <= 2005), 1);
        @(negedge clk);
        checkOutput("timeout_run_en", int'(run_en), 1);

        $display("[TB] randomized edits");
        for (int n = 0; n < 6; n++) begin
            logic [15:0] cur;
            if ($urandom_range(0, 4) == 0) cur = 16'($urandom_range(0, 65535));
            else cur = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9)),
                        4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
            applyStimulus(cur, $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
        end

        repeat (50) @(negedge clk);
        checkOutput("mode_queue_drained", exp_mode_q.size(), 0);
        checkOutput("load_queue_drained", exp_load_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
